// File: rtl/nios2_system_jtag_pkg.sv
// Shared types and constants for the Nios II debug-TAP JTAG driver.
package nios2_system_jtag_pkg;
  localparam int DATA_W    = 64;
  localparam int IDX_W     = 6;   // bit index into a DATA_W scan
  localparam int LEN_W     = 7;   // wide enough to hold 64 without wrapping
  localparam int CMD_LEN_W = 6;   // command encoding: 0 means 64

  // Test-Logic-Reset: TLR_LEN cells of TMS=1, then one TMS=0 into Run-Test/Idle.
  localparam int TLR_LEN = 5;

  // Preamble TMS patterns from Run-Test/Idle into Shift, LSB is the first TCK.
  localparam logic [3:0] IR_PRE_TMS = 4'b0011; // 1,1,0,0
  localparam int         IR_PRE_LEN = 4;
  localparam logic [3:0] DR_PRE_TMS = 4'b0001; // 1,0,0
  localparam int         DR_PRE_LEN = 3;

  // Exit1 -> Update -> Run-Test/Idle.
  localparam int POST_LEN = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_TLR, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_t;

  typedef struct packed {
    logic              is_ir;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic logic pre_tms(input logic is_ir, input logic [1:0] idx);
    return is_ir ? IR_PRE_TMS[idx] : DR_PRE_TMS[idx];
  endfunction
endpackage

// File: rtl/nios2_system_jtag_tap_driver_if.sv
// Command/response handshake bundle between a host and the JTAG driver.
interface nios2_system_jtag_tap_driver_if;
  import nios2_system_jtag_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_is_ir;
  logic [CMD_LEN_W-1:0] cmd_len;
  logic [DATA_W-1:0]    cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_data;

  modport master (
    output cmd_valid, cmd_is_ir, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_is_ir, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/nios2_system_jtag_tck_gen.sv
// TCK bit-cell timer: each cell is CLK_DIV cycles low then CLK_DIV high.
module nios2_system_jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tck,
  output logic o_cell_start, // closing edge of this cycle begins the next cell
  output logic o_rise        // first cycle with tck high; sample tdo here
);
  localparam int CELL = 2 * CLK_DIV;
  localparam int PW   = (CELL > 2) ? $clog2(CELL) : 1;

  logic [PW-1:0] r_ph, w_ph_n;
  logic          r_tck;

  assign o_cell_start = i_en && (r_ph == PW'(CELL - 1));
  assign o_rise       = i_en && (r_ph == PW'(CLK_DIV));
  assign o_tck        = r_tck;

  // Phase advance; parks at 0 while disabled so the first cell starts low.
  always_comb begin
    w_ph_n = '0;
    if (i_en && !o_cell_start) w_ph_n = r_ph + PW'(1);
  end

  // Phase and registered tck (high for the second half of each cell).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph  <= '0;
      r_tck <= 1'b0;
    end else begin
      r_ph  <= w_ph_n;
      r_tck <= i_en && (w_ph_n >= PW'(CLK_DIV));
    end
  end
endmodule

// File: rtl/nios2_system_jtag_tap_driver.sv
// Host-side JTAG initiator: walks the TAP from Run-Test/Idle through an IR or
// DR shift and back, returning the captured TDO bits.
module nios2_system_jtag_tap_driver
  import nios2_system_jtag_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  nios2_system_jtag_tap_driver_if.slave bus,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo
);
  state_t            r_state, w_state_n;
  logic [LEN_W-1:0]  r_cnt, w_cnt_n, w_plen;
  cmd_t              r_cmd, w_cmd_n;
  logic [DATA_W-1:0] r_cap;
  logic              r_unknown, r_init, r_tms, r_tdi;
  logic              w_tms_n, w_tdi_n;
  logic              w_en, w_cell_start, w_rise, w_last, w_ready, w_accept;

  assign w_en = (r_state == S_TLR) || (r_state == S_PRE) ||
                (r_state == S_SHIFT) || (r_state == S_POST);

  nios2_system_jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk          (clk),
    .rst          (reset),
    .i_en         (w_en),
    .o_tck        (tck),
    .o_cell_start (w_cell_start),
    .o_rise       (w_rise)
  );

  // r_init holds off cmd_ready for the first cycle out of reset.
  assign w_ready       = (r_state == S_IDLE) && r_init;
  assign w_accept      = w_ready && bus.cmd_valid;
  assign bus.cmd_ready = w_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = (r_state == S_RESP) ? r_cap : '0;
  assign tms           = r_tms;
  assign tdi           = r_tdi;

  // Number of TCK cells spent in the current phase.
  always_comb begin
    w_plen = LEN_W'(1);
    case (r_state)
      S_TLR:   w_plen = LEN_W'(TLR_LEN + 1);
      S_PRE:   w_plen = r_cmd.is_ir ? LEN_W'(IR_PRE_LEN) : LEN_W'(DR_PRE_LEN);
      S_SHIFT: w_plen = r_cmd.len;
      S_POST:  w_plen = LEN_W'(POST_LEN);
      default: ;
    endcase
  end

  assign w_last = (r_cnt == w_plen - LEN_W'(1));

  // Next-state: phases advance one cell at a time on cell boundaries.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cmd_n   = r_cmd;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_cmd_n.is_ir = bus.cmd_is_ir;
        w_cmd_n.len   = (bus.cmd_len == '0) ? LEN_W'(DATA_W) : {1'b0, bus.cmd_len};
        w_cmd_n.data  = bus.cmd_data;
        w_cnt_n       = '0;
        w_state_n     = r_unknown ? S_TLR : S_PRE;
      end
      S_TLR, S_PRE, S_SHIFT, S_POST: if (w_cell_start) begin
        if (w_last) begin
          w_cnt_n = '0;
          case (r_state)
            S_TLR:   w_state_n = S_PRE;
            S_PRE:   w_state_n = S_SHIFT;
            S_SHIFT: w_state_n = S_POST;
            default: w_state_n = S_RESP;
          endcase
        end else begin
          w_cnt_n = r_cnt + LEN_W'(1);
        end
      end
      S_RESP: if (bus.rsp_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pin values for the cell that begins at the coming edge, so TMS/TDI are
  // registered and only move when a new cell starts.
  always_comb begin
    w_tms_n = 1'b0;
    w_tdi_n = 1'b0;
    case (w_state_n)
      S_TLR:   w_tms_n = (w_cnt_n < LEN_W'(TLR_LEN));
      S_PRE:   w_tms_n = pre_tms(w_cmd_n.is_ir, w_cnt_n[1:0]);
      S_SHIFT: begin
        w_tms_n = (w_cnt_n == w_cmd_n.len - LEN_W'(1));
        w_tdi_n = w_cmd_n.data[w_cnt_n[IDX_W-1:0]];
      end
      S_POST:  w_tms_n = (w_cnt_n == '0);
      default: ;
    endcase
  end

  // FSM, command and pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_unknown <= 1'b1;
      r_init    <= 1'b0;
      r_tms     <= 1'b0;
      r_tdi     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cmd   <= w_cmd_n;
      r_init  <= 1'b1;
      r_tms   <= w_tms_n;
      r_tdi   <= w_tdi_n;
      if (r_state == S_TLR && w_cell_start && w_last) r_unknown <= 1'b0;
    end
  end

  // TDO capture, one bit per shift cell while tck is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cap <= '0;
    else if (w_accept)
      r_cap <= '0;
    else if (r_state == S_SHIFT && w_rise)
      r_cap[r_cnt[IDX_W-1:0]] <= tdo;
  end
endmodule

// File: tb/tb_nios2_system_jtag_tap_driver.sv
// Directed bench for the JTAG TAP driver: two instances (CLK_DIV=2 and 1).
module tb_nios2_system_jtag_tap_driver;
  logic clk = 1'b0;
  logic reset;
  logic tdo_tie;
  logic tck0, tms0, tdi0, tdo0;
  logic tck1, tms1, tdi1, tdo1;

  always #5 clk = ~clk;

  nios2_system_jtag_tap_driver_if bus0 ();
  nios2_system_jtag_tap_driver_if bus1 ();

  assign tdo0 = tdo_tie ? 1'b1 : tdi0;
  // Correct data only while tck is high: proves the sample lands in that cycle.
  assign tdo1 = tck1 ? tdi1 : ~tdi1;

  nios2_system_jtag_tap_driver #(.CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .tck(tck0), .tms(tms0), .tdi(tdi0), .tdo(tdo0)
  );

  nios2_system_jtag_tap_driver #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tms_h [512];
  logic tdi_h [512];
  int   n0 = 0;
  always @(posedge tck0) begin
    tms_h[n0 % 512] = tms0;
    tdi_h[n0 % 512] = tdi0;
    n0 = n0 + 1;
  end

  int n1 = 0, last1 = 0, per1 = 0;
  logic [63:0] tms1_h = '0;
  always @(posedge tck1) begin
    per1 = cyc - last1;
    last1 = cyc;
    if (n1 < 64) tms1_h[n1] = tms1;
    n1 = n1 + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hvec(input bit sel_tdi, input int base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v[i] = sel_tdi ? tdi_h[(base + i) % 512] : tms_h[(base + i) % 512];
    return v;
  endfunction

  // One command on dut0; leaves the response unacknowledged when hold is set.
  task automatic scan0(input logic ir, input logic [5:0] len, input logic [63:0] data,
                       input bit hold, output logic [63:0] rsp, output int lat,
                       output int ntck, output int base);
    int c0, k;
    bit to;
    to = 1'b0;
    bus0.cmd_is_ir = ir;
    bus0.cmd_len   = len;
    bus0.cmd_data  = data;
    bus0.cmd_valid = 1'b1;
    k = 0;
    while (bus0.cmd_ready !== 1'b1 && k < 50) begin tick; k++; end
    if (k >= 50) to = 1'b1;
    base = n0;
    c0 = cyc;
    tick;
    bus0.cmd_valid = 1'b0;
    k = 0;
    while (bus0.rsp_valid !== 1'b1 && k < 2000) begin tick; k++; end
    if (k >= 2000) to = 1'b1;
    lat  = cyc - c0;
    rsp  = bus0.rsp_data;
    ntck = n0 - base;
    chk("scan_timeout", 64'(to), 64'd0);
    if (!hold) begin
      bus0.rsp_ready = 1'b1;
      tick;
      bus0.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] rsp;
    int lat, nt, b, c0, k, bad;

    reset = 1'b1;
    tdo_tie = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_is_ir = 1'b0; bus0.cmd_len = '0; bus0.cmd_data = '0;
    bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_is_ir = 1'b0; bus1.cmd_len = '0; bus1.cmd_data = '0;
    bus1.rsp_ready = 1'b0;
    repeat (3) tick;

    chk("rst_tck", 64'(tck0), 64'd0);
    chk("rst_tms", 64'(tms0), 64'd0);
    chk("rst_tdi", 64'(tdi0), 64'd0);
    chk("rst_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus0.rsp_data, 64'd0);
    chk("rst_cmd_ready", 64'(bus0.cmd_ready), 64'd0);
    reset = 1'b0;
    chk("first_cycle_ready", 64'(bus0.cmd_ready), 64'd0);
    tick;
    chk("ready_after_init", 64'(bus0.cmd_ready), 64'd1);

    // DR len 8 after reset (TLR taken), loopback.
    scan0(1'b0, 6'd8, 64'hA5, 1'b0, rsp, lat, nt, b);
    chk("t1_rsp", rsp, 64'hA5);
    chk("t1_ntck", 64'(nt), 64'd19);
    chk("t1_tms", hvec(1'b0, b, 19), 64'h3005F);
    chk("t1_lat", 64'(lat), 64'd77);

    // IR len 2, tdo tied high, no TLR.
    tdo_tie = 1'b1;
    scan0(1'b1, 6'd2, 64'h2, 1'b0, rsp, lat, nt, b);
    chk("t2_rsp", rsp, 64'h3);
    chk("t2_ntck", 64'(nt), 64'd8);
    chk("t2_tms", hvec(1'b0, b, 8), 64'h63);
    chk("t2_tdi", hvec(1'b1, b, 8), 64'h20);
    chk("t2_lat", 64'(lat), 64'd33);
    tdo_tie = 1'b0;

    // len 0 encodes a 64-bit shift.
    scan0(1'b0, 6'd0, 64'hFFFF_0000_1234_5678, 1'b0, rsp, lat, nt, b);
    chk("t3_rsp", rsp, 64'hFFFF_0000_1234_5678);
    chk("t3_ntck", 64'(nt), 64'd69);
    chk("t3_lat", 64'(lat), 64'd277);
    chk("t3_shift_tdi", hvec(1'b1, b + 3, 64), 64'hFFFF_0000_1234_5678);

    // Response back-pressure with a command pending.
    scan0(1'b0, 6'd4, 64'h9, 1'b1, rsp, lat, nt, b);
    chk("t4_rsp", rsp, 64'h9);
    bus0.cmd_is_ir = 1'b0; bus0.cmd_len = 6'd3; bus0.cmd_data = 64'h5; bus0.cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 64'h9 ||
          bus0.cmd_ready !== 1'b0 || tck0 !== 1'b0) bad++;
    end
    chk("t4_hold_stable", 64'(bad), 64'd0);
    bus0.rsp_ready = 1'b1;
    tick;
    bus0.rsp_ready = 1'b0;
    chk("t4_idle_ready", 64'(bus0.cmd_ready), 64'd1);
    chk("t4_rsp_cleared", 64'(bus0.rsp_valid), 64'd0);
    b = n0; c0 = cyc;
    tick;
    bus0.cmd_valid = 1'b0;
    chk("t4_accepted", 64'(bus0.cmd_ready), 64'd0);
    k = 0;
    while (bus0.rsp_valid !== 1'b1 && k < 2000) begin tick; k++; end
    chk("t4_timeout", 64'(k >= 2000), 64'd0);
    chk("t4b_rsp", bus0.rsp_data, 64'h5);
    chk("t4b_ntck", 64'(n0 - b), 64'd8);
    chk("t4b_lat", 64'(cyc - c0), 64'd33);
    bus0.rsp_ready = 1'b1;
    tick;
    bus0.rsp_ready = 1'b0;
    b = n0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus0.rsp_valid !== 1'b0 || bus0.cmd_ready !== 1'b1) bad++;
    end
    chk("t4_no_dup", 64'(bad + (n0 - b)), 64'd0);

    // Reset during shift bit 3.
    bus0.cmd_is_ir = 1'b0; bus0.cmd_len = 6'd8; bus0.cmd_data = 64'hFF; bus0.cmd_valid = 1'b1;
    k = 0;
    while (bus0.cmd_ready !== 1'b1 && k < 50) begin tick; k++; end
    b = n0;
    tick;
    bus0.cmd_valid = 1'b0;
    while (n0 - b < 7 && k < 500) begin tick; k++; end
    chk("t5_wait", 64'(k >= 500), 64'd0);
    chk("t5_pre_tdi", 64'(tdi0), 64'd1);
    chk("t5_pre_tck", 64'(tck0), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_tck", 64'(tck0), 64'd0);
    chk("t5_tms", 64'(tms0), 64'd0);
    chk("t5_tdi", 64'(tdi0), 64'd0);
    chk("t5_rsp_valid", 64'(bus0.rsp_valid), 64'd0);
    chk("t5_cmd_ready", 64'(bus0.cmd_ready), 64'd0);
    tick; tick;
    reset = 1'b0;
    scan0(1'b0, 6'd4, 64'h6, 1'b0, rsp, lat, nt, b);
    chk("t5_ntck", 64'(nt), 64'd15);
    chk("t5_tlr_tms", hvec(1'b0, b, 6), 64'h1F);
    chk("t5_rsp", rsp, 64'h6);
    chk("t5_lat", 64'(lat), 64'd61);

    // CLK_DIV=1 instance: warm-up scan takes TLR, then a timed DR len 4.
    bus1.cmd_is_ir = 1'b0; bus1.cmd_len = 6'd4; bus1.cmd_data = 64'h3; bus1.cmd_valid = 1'b1;
    k = 0;
    while (bus1.cmd_ready !== 1'b1 && k < 50) begin tick; k++; end
    tick;
    bus1.cmd_valid = 1'b0;
    while (bus1.rsp_valid !== 1'b1 && k < 2000) begin tick; k++; end
    chk("t6w_rsp", bus1.rsp_data, 64'h3);
    bus1.rsp_ready = 1'b1;
    tick;
    bus1.rsp_ready = 1'b0;
    bus1.cmd_data = 64'hA; bus1.cmd_valid = 1'b1;
    k = 0;
    while (bus1.cmd_ready !== 1'b1 && k < 50) begin tick; k++; end
    c0 = cyc; b = n1;
    tick;
    bus1.cmd_valid = 1'b0;
    while (bus1.rsp_valid !== 1'b1 && k < 2000) begin tick; k++; end
    chk("t6_timeout", 64'(k >= 2000), 64'd0);
    chk("t6_lat", 64'(cyc - c0), 64'd19);
    chk("t6_rsp", bus1.rsp_data, 64'hA);
    chk("t6_ntck", 64'(n1 - b), 64'd9);
    chk("t6_period", 64'(per1), 64'd2);
    chk("t6_warm_tlr_tms", tms1_h[5:0], 64'h1F);
    bus1.rsp_ready = 1'b1;
    tick;
    bus1.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
